i2c_slave_ctrl: RTL and testbench

I2C target (slave) controller: the responder at the other end of the bus driven by the I2C master. It answers a fixed 7-bit device address, takes a register-pointer byte, and then exposes a simple register bus. Write transfers produce one-cycle register write strobes. Read transfers fetch register data and shift it out on SDA. It sits between the SDA/SCL pads and a local register file, with the pointer auto-incrementing for burst access.

---
 rtl/i2c_slave_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_ctrl.sv
// I2C target controller: fixed 7-bit address, register-pointer byte, then
// auto-incrementing register writes/reads over a simple register bus.
module i2c_slave_ctrl #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         AWIDTH     = 8,
    parameter int         DWIDTH     = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic [AWIDTH-1:0] RegAddr,
    output logic [DWIDTH-1:0] RegWrData,
    output logic              RegWr,
    input  logic [DWIDTH-1:0] RegRdData,
    output logic              Busy,
    input  logic              SclPadIn,
    input  logic              SdaPadIn,
    output logic              SdaPadOut,
    output logic              SdaPadEn
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] DEV_ADDR = 4'd1;
    localparam logic [3:0] DEV_ACK  = 4'd2;
    localparam logic [3:0] PTR      = 4'd3;
    localparam logic [3:0] PTR_ACK  = 4'd4;
    localparam logic [3:0] WR_DATA  = 4'd5;
    localparam logic [3:0] WR_ACK   = 4'd6;
    localparam logic [3:0] RD_DATA  = 4'd7;
    localparam logic [3:0] RD_ACK   = 4'd8;
    localparam logic [3:0] IGNORE   = 4'd9;

    localparam logic [AWIDTH-1:0] PTR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

    logic       scl_meta, scl_sync, scl_hist;
    logic       sda_meta, sda_sync, sda_hist;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [3:0] state;
    logic [3:0] bit_cnt;
    logic [6:0] shift;
    logic [7:0] byte_in;
    logic [7:0] tx;
    logic       rw;
    logic       inc_pending;

    assign SdaPadOut = 1'b0;

    assign scl_rise  = scl_sync & ~scl_hist;
    assign scl_fall  = ~scl_sync & scl_hist;
    assign start_det = ~sda_sync & sda_hist & scl_sync;
    assign stop_det  = sda_sync & ~sda_hist & scl_sync;
    assign byte_in   = {shift, sda_sync};

    // Pad synchronizers plus one history stage; reset to the idle-bus level.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_hist <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_meta <= SclPadIn;
            scl_sync <= scl_meta;
            scl_hist <= scl_sync;
            sda_meta <= SdaPadIn;
            sda_sync <= sda_meta;
            sda_hist <= sda_sync;
        end
    end

    // Protocol FSM; START/STOP override any bit-level event in the same cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            shift       <= 7'd0;
            tx          <= 8'hFF;
            rw          <= 1'b0;
            inc_pending <= 1'b0;
            RegAddr     <= {AWIDTH{1'b0}};
            RegWrData   <= {DWIDTH{1'b0}};
            RegWr       <= 1'b0;
            Busy        <= 1'b0;
            SdaPadEn    <= 1'b1;
        end else begin
            RegWr       <= 1'b0;
            inc_pending <= 1'b0;
            if (inc_pending) begin
                RegAddr <= RegAddr + PTR_ONE;
            end
            if (stop_det) begin
                state    <= IDLE;
                bit_cnt  <= 4'd0;
                Busy     <= 1'b0;
                SdaPadEn <= 1'b1;
            end else if (start_det) begin
                state    <= DEV_ADDR;
                bit_cnt  <= 4'd0;
                SdaPadEn <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        SdaPadEn <= 1'b1;
                    end
                    DEV_ADDR, PTR, WR_DATA: begin
                        if (scl_rise) begin
                            shift <= byte_in[6:0];
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd8;
                                if (state == DEV_ADDR) begin
                                    if (byte_in[7:1] == SLAVE_ADDR) begin
                                        state <= DEV_ACK;
                                        Busy  <= 1'b1;
                                        rw    <= byte_in[0];
                                    end else begin
                                        state <= IGNORE;
                                    end
                                end else if (state == PTR) begin
                                    RegAddr <= byte_in[AWIDTH-1:0];
                                    state   <= PTR_ACK;
                                end else begin
                                    RegWrData   <= byte_in;
                                    RegWr       <= 1'b1;
                                    inc_pending <= 1'b1;
                                    state       <= WR_ACK;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    DEV_ACK, PTR_ACK, WR_ACK: begin
                        // First fall after the 8th rise drives ACK; the 9th fall ends it.
                        if (scl_rise) begin
                            bit_cnt <= 4'd9;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd9) begin
                                bit_cnt <= 4'd0;
                                if (state == DEV_ACK && rw) begin
                                    tx       <= {RegRdData[6:0], 1'b1};
                                    SdaPadEn <= RegRdData[7];
                                    state    <= RD_DATA;
                                end else if (state == DEV_ACK) begin
                                    SdaPadEn <= 1'b1;
                                    state    <= PTR;
                                end else begin
                                    SdaPadEn <= 1'b1;
                                    state    <= WR_DATA;
                                end
                            end else begin
                                SdaPadEn <= 1'b0;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                SdaPadEn <= 1'b1;
                                state    <= RD_ACK;
                            end else begin
                                SdaPadEn <= tx[7];
                                tx       <= {tx[6:0], 1'b1};
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            RegAddr <= RegAddr + PTR_ONE;
                            if (!sda_sync) begin
                                bit_cnt <= 4'd9;
                            end else begin
                                state <= IGNORE;
                                Busy  <= 1'b0;
                            end
                        end else if (scl_fall && bit_cnt == 4'd9) begin
                            bit_cnt  <= 4'd0;
                            tx       <= {RegRdData[6:0], 1'b1};
                            SdaPadEn <= RegRdData[7];
                            state    <= RD_DATA;
                        end
                    end
                    IGNORE: begin
                        SdaPadEn <= 1'b1;
                    end
                    default: begin
                        state    <= IDLE;
                        SdaPadEn <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: a bit-banged I2C master, a register-file
// model, a table of write transactions and hand-written corner-case sequences.
module tb_i2c_slave_ctrl;

    localparam int Q = 8;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [7:0] RegAddr, RegWrData, RegRdData;
    logic       RegWr, Busy, SclPadIn, SdaPadIn, SdaPadOut, SdaPadEn;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] mem [0:255];

    int checks = 0;
    int failures = 0;
    logic [15:0] wr_log [$];
    logic busy_seen = 1'b0;
    logic en_low_seen = 1'b0;

    // Open-drain bus: the line is low if either side pulls it low.
    assign SclPadIn  = scl_m;
    assign SdaPadIn  = sda_m & SdaPadEn;
    assign RegRdData = mem[RegAddr];

    always #5 Clk = ~Clk;

    i2c_slave_ctrl #(.SLAVE_ADDR(7'h50), .AWIDTH(8), .DWIDTH(8)) dut (
        .Clk(Clk), .Rst(Rst), .RegAddr(RegAddr), .RegWrData(RegWrData),
        .RegWr(RegWr), .RegRdData(RegRdData), .Busy(Busy),
        .SclPadIn(SclPadIn), .SdaPadIn(SdaPadIn),
        .SdaPadOut(SdaPadOut), .SdaPadEn(SdaPadEn)
    );

    always @(negedge Clk) begin
        if (RegWr) wr_log.push_back({RegAddr, RegWrData});
        if (Busy) busy_seen = 1'b1;
        if (!SdaPadEn) en_low_seen = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge Clk);
    endtask

    task automatic bit_out(input logic b);
        sda_m = b; wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(v[i]);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        ack = (SdaPadIn == 1'b0);
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic read_byte(input logic ack_lvl, output logic [7:0] v);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_q();
            scl_m = 1'b1; wait_q();
            v[i] = SdaPadIn;
            wait_q();
            scl_m = 1'b0; wait_q();
        end
        bit_out(ack_lvl);
    endtask

    task automatic start_c();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic stop_c();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    typedef struct {
        logic [7:0]  dev;
        logic [7:0]  ptr;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [3:0]  acks;
        int          nwr;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [7:0]  fin;
        logic        busy;
    } vec_t;

    vec_t vt [3];

    initial begin
        logic [3:0] a;
        logic       ak;
        logic [7:0] b0, b1;
        int         base;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h20] = 8'h96;
        mem[8'h21] = 8'h3C;

        vt[0] = '{8'hA0, 8'h10, 8'h5A, 8'hC3, 4'b1111, 2, 16'h105A, 16'h11C3, 8'h12, 1'b1};
        vt[1] = '{8'hA0, 8'hFF, 8'h11, 8'h22, 4'b1111, 2, 16'hFF11, 16'h0022, 8'h01, 1'b1};
        vt[2] = '{8'hA2, 8'h10, 8'h33, 8'h44, 4'b0000, 0, 16'h0000, 16'h0000, 8'h01, 1'b0};

        repeat (5) @(negedge Clk);
        chk("rst_regaddr", RegAddr, 8'h00);
        chk("rst_wrdata", RegWrData, 8'h00);
        chk("rst_regwr", RegWr, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_sdaen", SdaPadEn, 1'b1);
        chk("rst_sdaout", SdaPadOut, 1'b0);
        Rst = 1'b0;
        repeat (5) @(negedge Clk);

        for (int v = 0; v < 3; v++) begin
            base = wr_log.size();
            busy_seen = 1'b0;
            en_low_seen = 1'b0;
            start_c();
            send_byte(vt[v].dev, ak); a[3] = ak;
            send_byte(vt[v].ptr, ak); a[2] = ak;
            send_byte(vt[v].d0, ak);  a[1] = ak;
            send_byte(vt[v].d1, ak);  a[0] = ak;
            stop_c();
            wait_q();
            chk($sformatf("v%0d_acks", v), a, vt[v].acks);
            chk($sformatf("v%0d_nwr", v), wr_log.size() - base, vt[v].nwr);
            for (int k = 0; k < vt[v].nwr && base + k < wr_log.size(); k++)
                chk($sformatf("v%0d_wr%0d", v, k), wr_log[base + k], (k == 0) ? vt[v].w0 : vt[v].w1);
            chk($sformatf("v%0d_regaddr", v), RegAddr, vt[v].fin);
            chk($sformatf("v%0d_busy_seen", v), busy_seen, vt[v].busy);
            chk($sformatf("v%0d_en_low_seen", v), en_low_seen, vt[v].acks != 4'b0000);
            chk($sformatf("v%0d_busy_end", v), Busy, 1'b0);
            chk($sformatf("v%0d_sdaen_end", v), SdaPadEn, 1'b1);
        end

        // Read with repeated START after setting the pointer.
        base = wr_log.size();
        start_c();
        send_byte(8'hA0, ak); chk("rd_ack_addr", ak, 1'b1);
        send_byte(8'h20, ak); chk("rd_ack_ptr", ak, 1'b1);
        start_c();
        send_byte(8'hA1, ak); chk("rd_ack_addr_r", ak, 1'b1);
        chk("rd_busy", Busy, 1'b1);
        read_byte(1'b0, b0);
        read_byte(1'b1, b1);
        stop_c();
        wait_q();
        chk("rd_byte0", b0, 8'h96);
        chk("rd_byte1", b1, 8'h3C);
        chk("rd_regaddr", RegAddr, 8'h22);
        chk("rd_nwr", wr_log.size() - base, 0);
        chk("rd_busy_end", Busy, 1'b0);

        // Abort mid-byte with STOP.
        base = wr_log.size();
        start_c();
        send_byte(8'hA0, ak);
        send_byte(8'h05, ak);
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
        stop_c();
        wait_q();
        chk("abs_nwr", wr_log.size() - base, 0);
        chk("abs_regaddr", RegAddr, 8'h05);
        chk("abs_sdaen", SdaPadEn, 1'b1);
        chk("abs_busy", Busy, 1'b0);

        // Abort mid-byte with repeated START; the new address must be accepted.
        base = wr_log.size();
        start_c();
        send_byte(8'hA0, ak);
        send_byte(8'h05, ak);
        bit_out(1'b0); bit_out(1'b1); bit_out(1'b1); bit_out(1'b0);
        start_c();
        send_byte(8'hA0, ak);
        chk("aba_ack", ak, 1'b1);
        chk("aba_nwr_mid", wr_log.size() - base, 0);
        send_byte(8'h30, ak);
        send_byte(8'h77, ak);
        stop_c();
        wait_q();
        chk("aba_nwr", wr_log.size() - base, 1);
        if (wr_log.size() > base) chk("aba_wr", wr_log[base], 16'h3077);
        chk("aba_regaddr", RegAddr, 8'h31);

        // Reset while the target drives a 0 data bit.
        start_c();
        send_byte(8'hA0, ak);
        send_byte(8'h21, ak);
        start_c();
        send_byte(8'hA1, ak);
        chk("rr_drive_low", SdaPadEn, 1'b0);
        @(posedge Clk);
        #2 Rst = 1'b1;
        #1;
        chk("rr_sdaen", SdaPadEn, 1'b1);
        chk("rr_regaddr", RegAddr, 8'h00);
        chk("rr_wrdata", RegWrData, 8'h00);
        chk("rr_busy", Busy, 1'b0);
        chk("rr_regwr", RegWr, 1'b0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (5) @(negedge Clk);
        Rst = 1'b0;
        repeat (5) @(negedge Clk);
        chk("rr_sdaen_after", SdaPadEn, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
